// File: rtl/call_scheduler_if.sv
// Call scheduler bus: floor-call buttons and car status in, destination and status out.
interface call_scheduler_if;
    logic [7:0] req_btn;
    logic [2:0] cur_floor;
    logic       car_idle;
    logic       arrived;
    logic [2:0] dest_floor;
    logic       dest_load;
    logic [7:0] pending;
    logic       sweep_up;
    logic       busy;

    // Drives the car status and call buttons, observes the scheduler.
    modport master (
        output req_btn, cur_floor, car_idle, arrived,
        input  dest_floor, dest_load, pending, sweep_up, busy
    );

    // The scheduler itself.
    modport slave (
        input  req_btn, cur_floor, car_idle, arrived,
        output dest_floor, dest_load, pending, sweep_up, busy
    );
endinterface

// File: rtl/call_scheduler.sv
// SCAN-style elevator call scheduler: latches floor calls, picks the next
// destination in the current sweep direction, issues it, and waits out the
// car's travel and door dwell before choosing again.
module call_scheduler #(
    parameter int unsigned DWELL_CYCLES = 4
) (
    input logic             CLK,
    input logic             reset,
    call_scheduler_if.slave bus
);

    typedef enum logic [2:0] {IDLE, SELECT, ISSUE, TRAVEL, DWELL} state_t;

    state_t     state;
    state_t     state_next;
    logic [7:0] pending_q;
    logic [2:0] dest_q;
    logic       sweep_q;
    logic [7:0] cnt_q;

    logic [7:0] clr_mask;
    logic [7:0] others;
    logic       load_sel;
    logic       load_cnt;

    logic       up_found;
    logic [2:0] up_idx;
    logic       dn_found;
    logic [2:0] dn_idx;
    logic       sel_found;
    logic [2:0] sel_idx;
    logic       sel_dir;

    assign bus.pending    = pending_q;
    assign bus.dest_floor = dest_q;
    assign bus.sweep_up   = sweep_q;
    assign bus.dest_load  = (state == ISSUE);
    assign bus.busy       = (state != IDLE);

    // Calls other than the one at the car's own floor.
    assign others = pending_q & ~(8'd1 << bus.cur_floor);

    // Nearest pending floor above and below the car, then pick by sweep direction.
    always_comb begin
        up_found  = 1'b0;
        up_idx    = '0;
        dn_found  = 1'b0;
        dn_idx    = '0;
        sel_found = 1'b0;
        sel_idx   = '0;
        sel_dir   = sweep_q;
        for (int unsigned i = 0; i < 8; i++) begin
            if (pending_q[i] && (3'(i) > bus.cur_floor) && !up_found) begin
                up_found = 1'b1;
                up_idx   = 3'(i);
            end
            if (pending_q[i] && (3'(i) < bus.cur_floor)) begin
                dn_found = 1'b1;
                dn_idx   = 3'(i);
            end
        end
        sel_found = up_found | dn_found;
        if (sweep_q) begin
            if (up_found) begin
                sel_idx = up_idx;
                sel_dir = 1'b1;
            end else begin
                sel_idx = dn_idx;
                sel_dir = 1'b0;
            end
        end else begin
            if (dn_found) begin
                sel_idx = dn_idx;
                sel_dir = 1'b0;
            end else begin
                sel_idx = up_idx;
                sel_dir = 1'b1;
            end
        end
    end

    // State register.
    always_ff @(posedge CLK) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state decode and datapath control strobes.
    always_comb begin
        state_next = state;
        clr_mask   = '0;
        load_sel   = 1'b0;
        load_cnt   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.car_idle) begin
                    clr_mask = 8'd1 << bus.cur_floor;
                    if (others != '0) state_next = SELECT;
                end
            end
            SELECT: begin
                if (sel_found) begin
                    load_sel   = 1'b1;
                    state_next = ISSUE;
                end else begin
                    state_next = IDLE;
                end
            end
            ISSUE: state_next = TRAVEL;
            TRAVEL: begin
                if (bus.arrived) begin
                    clr_mask   = 8'd1 << dest_q;
                    load_cnt   = 1'b1;
                    state_next = DWELL;
                end
            end
            DWELL: begin
                if (cnt_q == '0) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Call latch, destination/direction registers and dwell counter.
    always_ff @(posedge CLK) begin
        if (reset) begin
            pending_q <= '0;
            dest_q    <= '0;
            sweep_q   <= 1'b1;
            cnt_q     <= '0;
        end else begin
            // Clear first, then OR in the buttons so a held button wins.
            pending_q <= (pending_q & ~clr_mask) | bus.req_btn;
            if (load_sel) begin
                dest_q  <= sel_idx;
                sweep_q <= sel_dir;
            end
            if (load_cnt)
                cnt_q <= 8'(DWELL_CYCLES - 1);
            else if ((state == DWELL) && (cnt_q != '0))
                cnt_q <= cnt_q - 8'd1;
        end
    end

endmodule

// File: tb/tb_call_scheduler.sv
// Directed bench for call_scheduler: expected dispatches go into a scoreboard
// queue; a monitor pops one on every dest_load and checks floor, direction and cycle.
module tb_call_scheduler;

    typedef struct {
        logic [2:0]  floor;
        logic        sweep;
        int unsigned cyc;
    } exp_t;

    logic        CLK;
    logic        reset;
    int unsigned cyc;
    int unsigned n_checks;
    int unsigned n_fail;
    exp_t        sb[$];

    call_scheduler_if bus();

    call_scheduler #(.DWELL_CYCLES(4)) dut (
        .CLK   (CLK),
        .reset (reset),
        .bus   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic sample();
        @(negedge CLK);
    endtask

    task automatic expect_load(input logic [2:0] floor, input logic sweep, input int unsigned at);
        exp_t e;
        e.floor = floor;
        e.sweep = sweep;
        e.cyc   = at;
        sb.push_back(e);
    endtask

    // Monitor: every destination strobe must match the oldest expected dispatch.
    always @(negedge CLK) begin
        if (bus.dest_load === 1'b1) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_load: got dest_load=1 floor %0d expected no load (cycle %0d)",
                         bus.dest_floor, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("load_floor", 32'(bus.dest_floor), 32'(e.floor));
                check("load_sweep", 32'(bus.sweep_up), 32'(e.sweep));
                check("load_cycle", cyc, e.cyc);
            end
        end
    end

    initial begin
        int unsigned k;
        int unsigned a;
        n_checks = 0;
        n_fail   = 0;

        // Reset with all buttons pressed: they must be discarded.
        reset         = 1'b1;
        bus.req_btn   = 8'hFF;
        bus.cur_floor = 3'd0;
        bus.car_idle  = 1'b1;
        bus.arrived   = 1'b0;
        tick();
        tick();
        sample();
        check("rst_pending", 32'(bus.pending), 32'h00);
        check("rst_dest", 32'(bus.dest_floor), 32'd0);
        check("rst_load", 32'(bus.dest_load), 32'd0);
        check("rst_sweep", 32'(bus.sweep_up), 32'd1);
        check("rst_busy", 32'(bus.busy), 32'd0);
        reset       = 1'b0;
        bus.req_btn = 8'h00;
        tick();
        sample();
        check("post_rst_pending", 32'(bus.pending), 32'h00);

        // Single call to floor 5 from floor 0: dispatch at n+3, then travel and dwell.
        tick();
        k = cyc;
        bus.req_btn = 8'h20;
        expect_load(3'd5, 1'b1, k + 3);
        tick();
        bus.req_btn = 8'h00;
        sample();
        check("latch_pending", 32'(bus.pending), 32'h20);
        check("latch_busy", 32'(bus.busy), 32'd0);
        tick();
        sample();
        check("select_busy", 32'(bus.busy), 32'd1);
        tick();
        sample();
        check("issue_busy", 32'(bus.busy), 32'd1);
        tick();
        sample();
        check("travel_dest", 32'(bus.dest_floor), 32'd5);
        check("travel_busy", 32'(bus.busy), 32'd1);
        tick();
        a = cyc;
        bus.arrived   = 1'b1;
        bus.cur_floor = 3'd5;
        tick();
        bus.arrived = 1'b0;
        sample();
        check("arrive_clear", 32'(bus.pending), 32'h00);
        check("dwell1_busy", 32'(bus.busy), 32'd1);
        repeat (3) tick();
        sample();
        check("dwell4_busy", 32'(bus.busy), 32'd1);
        check("dwell4_cycle", cyc, a + 4);
        tick();
        sample();
        check("dwell_done_busy", 32'(bus.busy), 32'd0);

        // Arrival pulse while idle is ignored.
        tick();
        bus.arrived = 1'b1;
        tick();
        bus.arrived = 1'b0;
        sample();
        check("stray_arrive_busy", 32'(bus.busy), 32'd0);
        tick();
        sample();
        check("stray_arrive_busy2", 32'(bus.busy), 32'd0);

        // Call at the car's own floor is served in place.
        bus.cur_floor = 3'd2;
        tick();
        bus.req_btn = 8'h04;
        tick();
        bus.req_btn = 8'h00;
        sample();
        check("inplace_latched", 32'(bus.pending), 32'h04);
        tick();
        sample();
        check("inplace_cleared", 32'(bus.pending), 32'h00);
        check("inplace_busy", 32'(bus.busy), 32'd0);
        repeat (3) tick();
        sample();
        check("inplace_busy_late", 32'(bus.busy), 32'd0);

        // SCAN: from floor 3 going up with calls at 1 and 7 -> 7 first, then 1 going down.
        bus.cur_floor = 3'd3;
        tick();
        k = cyc;
        bus.req_btn = 8'h82;
        expect_load(3'd7, 1'b1, k + 3);
        tick();
        bus.req_btn = 8'h00;
        sample();
        check("scan_pending", 32'(bus.pending), 32'h82);
        repeat (4) tick();
        a = cyc;
        bus.arrived   = 1'b1;
        bus.cur_floor = 3'd7;
        expect_load(3'd1, 1'b0, a + 7);
        tick();
        bus.arrived = 1'b0;
        sample();
        check("scan_after_7", 32'(bus.pending), 32'h02);
        repeat (8) tick();
        sample();
        check("scan_travel_down", 32'(bus.sweep_up), 32'd0);
        check("scan_dest_1", 32'(bus.dest_floor), 32'd1);
        bus.arrived   = 1'b1;
        bus.cur_floor = 3'd1;
        tick();
        bus.arrived = 1'b0;
        repeat (5) tick();
        sample();
        check("scan_done_busy", 32'(bus.busy), 32'd0);
        check("scan_done_pending", 32'(bus.pending), 32'h00);

        // Held button on the destination floor survives the arrival clear.
        tick();
        k = cyc;
        bus.req_btn = 8'h08;
        expect_load(3'd3, 1'b1, k + 3);
        repeat (5) tick();
        bus.arrived   = 1'b1;
        bus.cur_floor = 3'd3;
        tick();
        bus.arrived = 1'b0;
        sample();
        check("setwins_pending", 32'(bus.pending), 32'h08);
        bus.req_btn = 8'h00;
        repeat (4) tick();
        sample();
        check("setwins_idle_busy", 32'(bus.busy), 32'd0);
        check("setwins_idle_pending", 32'(bus.pending), 32'h08);
        tick();
        sample();
        check("setwins_served", 32'(bus.pending), 32'h00);
        check("setwins_no_dispatch", 32'(bus.busy), 32'd0);

        // Reset in the middle of travel with every floor called.
        bus.cur_floor = 3'd0;
        tick();
        k = cyc;
        bus.req_btn = 8'hFF;
        expect_load(3'd1, 1'b1, k + 3);
        repeat (3) tick();
        sample();
        check("pre_rst_pending", 32'(bus.pending), 32'hFF);
        check("pre_rst_busy", 32'(bus.busy), 32'd1);
        reset = 1'b1;
        tick();
        sample();
        check("mid_rst_pending", 32'(bus.pending), 32'h00);
        check("mid_rst_dest", 32'(bus.dest_floor), 32'd0);
        check("mid_rst_load", 32'(bus.dest_load), 32'd0);
        check("mid_rst_sweep", 32'(bus.sweep_up), 32'd1);
        check("mid_rst_busy", 32'(bus.busy), 32'd0);
        reset       = 1'b0;
        bus.req_btn = 8'h00;
        tick();
        bus.arrived = 1'b1;
        tick();
        bus.arrived = 1'b0;
        sample();
        check("post_rst_arrive_busy", 32'(bus.busy), 32'd0);
        tick();
        sample();
        check("post_rst_arrive_busy2", 32'(bus.busy), 32'd0);
        check("post_rst_arrive_pending", 32'(bus.pending), 32'h00);
        check("post_rst_arrive_dest", 32'(bus.dest_floor), 32'd0);

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
